// File: rtl/pipelined_addsub_if.sv
// Operand and result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   // producer of operands and consumer of results
   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, carry, overflow
   );

   // the adder itself
   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, carry, overflow
   );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SLICE-bit ripple slice per
// stage, carry registered between stages, single global stall.
// WIDTH must be an integer multiple of SLICE.
module pipelined_addsub #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int STAGES = WIDTH / SLICE;

   logic             advance;
   logic [WIDTH-1:0] b_eff;

   // whole pipeline freezes only when a result is waiting and not taken
   assign advance      = !(bus.out_valid && !bus.out_ready);
   assign bus.in_ready = rst_n && advance;
   assign b_eff        = bus.b ^ {WIDTH{bus.sub}};

   // Stage k consumes the low slice of the operand bits still in flight and
   // appends its result slice above the slices already finished. Operand
   // registers shrink and sum registers grow by SLICE bits per stage, so the
   // last stage holds the complete WIDTH-bit result.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IN_W   = WIDTH - k * SLICE;
      localparam int DONE_W = (k + 1) * SLICE;

      logic [IN_W-1:0]   src_a;
      logic [IN_W-1:0]   src_b;
      logic              src_c;
      logic              src_v;
      logic [SLICE:0]    slice_sum;
      logic [DONE_W-1:0] nx_s;

      if (k == 0) begin : g_first
         assign src_a = bus.a;
         assign src_b = b_eff;
         assign src_c = bus.sub;
         assign src_v = bus.in_valid;
         assign nx_s  = slice_sum[SLICE-1:0];
      end else begin : g_next
         assign src_a = g_stage[k-1].g_pipe.st_a;
         assign src_b = g_stage[k-1].g_pipe.st_b;
         assign src_c = g_stage[k-1].g_pipe.st_c;
         assign src_v = g_stage[k-1].g_pipe.st_v;
         assign nx_s  = {slice_sum[SLICE-1:0], g_stage[k-1].g_pipe.st_s};
      end

      assign slice_sum = {1'b0, src_a[SLICE-1:0]} + {1'b0, src_b[SLICE-1:0]}
                       + {{SLICE{1'b0}}, src_c};

      if (k < STAGES - 1) begin : g_pipe
         logic                  st_v;
         logic                  st_c;
         logic [IN_W-SLICE-1:0] st_a;
         logic [IN_W-SLICE-1:0] st_b;
         logic [DONE_W-1:0]     st_s;

         // move a beat one slice forward; data only loads for valid beats
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               st_v <= 1'b0;
               st_c <= 1'b0;
               st_a <= '0;
               st_b <= '0;
               st_s <= '0;
            end else if (advance) begin
               st_v <= src_v;
               if (src_v) begin
                  st_c <= slice_sum[SLICE];
                  st_a <= src_a[IN_W-1:SLICE];
                  st_b <= src_b[IN_W-1:SLICE];
                  st_s <= nx_s;
               end
            end
         end
      end else begin : g_last
         logic             out_v;
         logic             out_c;
         logic             out_ov;
         logic [WIDTH-1:0] out_s;
         logic             msb_cin;

         // carry into the MSB recovered from the MSB's own sum bit
         assign msb_cin = src_a[SLICE-1] ^ src_b[SLICE-1] ^ slice_sum[SLICE-1];

         // result registers; flags and sum hold across bubbles
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               out_v  <= 1'b0;
               out_c  <= 1'b0;
               out_ov <= 1'b0;
               out_s  <= '0;
            end else if (advance) begin
               out_v <= src_v;
               if (src_v) begin
                  out_s  <= nx_s;
                  out_c  <= slice_sum[SLICE];
                  out_ov <= msb_cin ^ slice_sum[SLICE];
               end
            end
         end

         assign bus.out_valid = out_v;
         assign bus.sum       = out_s;
         assign bus.carry     = out_c;
         assign bus.overflow  = out_ov;
      end
   end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 16/4, legacy 4/1 and 8/8 configurations.
module tb_pipelined_addsub;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   miscompares;

   pipelined_addsub_if #(.WIDTH(16)) i16 ();
   pipelined_addsub_if #(.WIDTH(4))  i4 ();
   pipelined_addsub_if #(.WIDTH(8))  i8 ();

   pipelined_addsub #(.WIDTH(16), .SLICE(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));
   pipelined_addsub #(.WIDTH(4),  .SLICE(1)) u4  (.clk(clk), .rst_n(rst_n), .bus(i4));
   pipelined_addsub #(.WIDTH(8),  .SLICE(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(i8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {overflow, carry, sum}
   function automatic logic [17:0] model16(input logic [15:0] av, input logic [15:0] bv,
                                           input logic sv);
      logic [15:0] bx;
      logic [16:0] r;
      logic        v;
      bx = sv ? ~bv : bv;
      r  = {1'b0, av} + {1'b0, bx} + {16'd0, sv};
      v  = (av[15] == bx[15]) && (r[15] != av[15]);
      return {v, r};
   endfunction

   task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic [15:0] es, input logic ec, input logic ev);
      int n;
      i16.a = av; i16.b = bv; i16.sub = sv; i16.in_valid = 1'b1; i16.out_ready = 1'b1;
      @(posedge clk); #1;
      i16.in_valid = 1'b0;
      n = 1;
      while (!i16.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk({tag, " latency"}, n, 4);
      chk({tag, " sum"}, i16.sum, es);
      chk({tag, " carry"}, i16.carry, ec);
      chk({tag, " overflow"}, i16.overflow, ev);
      @(posedge clk); #1;
      chk({tag, " consumed"}, i16.out_valid, 0);
   endtask

   task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                      input logic [3:0] es, input logic ec, input logic ev);
      int n;
      i4.a = av; i4.b = bv; i4.sub = 1'b0; i4.in_valid = 1'b1; i4.out_ready = 1'b1;
      @(posedge clk); #1;
      i4.in_valid = 1'b0;
      n = 1;
      while (!i4.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk({tag, " latency"}, n, 4);
      chk({tag, " sum"}, i4.sum, es);
      chk({tag, " carry"}, i4.carry, ec);
      chk({tag, " overflow"}, i4.overflow, ev);
      @(posedge clk); #1;
   endtask

   task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic sv, input logic [7:0] es, input logic ec, input logic ev);
      int n;
      i8.a = av; i8.b = bv; i8.sub = sv; i8.in_valid = 1'b1; i8.out_ready = 1'b1;
      @(posedge clk); #1;
      i8.in_valid = 1'b0;
      n = 1;
      while (!i8.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk({tag, " latency"}, n, 1);
      chk({tag, " sum"}, i8.sum, es);
      chk({tag, " carry"}, i8.carry, ec);
      chk({tag, " overflow"}, i8.overflow, ev);
      @(posedge clk); #1;
   endtask

   logic [15:0] sa [8];
   logic [15:0] sb [8];
   logic        ss [8];
   logic [17:0] se [8];
   logic [15:0] pa [6];
   logic [15:0] pb [6];
   logic        ps [6];
   logic [17:0] q [$];
   logic [17:0] e;
   logic [17:0] front;
   int          sent;
   int          got;

   initial begin
      n_vec = 0;
      miscompares = 0;

      // reset held two edges with operands offered
      rst_n = 1'b0;
      i16.a = 16'h1234; i16.b = 16'h4321; i16.sub = 1'b0; i16.in_valid = 1'b1; i16.out_ready = 1'b1;
      i4.a = 4'h3; i4.b = 4'h5; i4.sub = 1'b0; i4.in_valid = 1'b1; i4.out_ready = 1'b1;
      i8.a = 8'h11; i8.b = 8'h22; i8.sub = 1'b0; i8.in_valid = 1'b1; i8.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", i16.out_valid, 0);
      chk("rst sum", i16.sum, 0);
      chk("rst carry", i16.carry, 0);
      chk("rst overflow", i16.overflow, 0);
      chk("rst in_ready", i16.in_ready, 0);
      chk("rst out_valid w4", i4.out_valid, 0);
      chk("rst out_valid w8", i8.out_valid, 0);
      rst_n = 1'b1;
      i16.in_valid = 1'b0; i4.in_valid = 1'b0; i8.in_valid = 1'b0;
      #1;
      chk("release in_ready", i16.in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("no spurious result", i16.out_valid, 0);
      end

      // carry chain and subtract corners
      op16("ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16("7fff+0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op16("0002-000e", 16'h0002, 16'h000E, 1'b1, 16'hFFF4, 1'b0, 1'b0);
      op16("8000-0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      op16("0005-0005", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);

      // streaming: 8 back-to-back beats, results on 8 consecutive cycles
      for (int i = 0; i < 8; i++) begin
         sa[i] = 16'($urandom);
         sb[i] = 16'($urandom);
         ss[i] = 1'($urandom_range(0, 1));
         se[i] = model16(sa[i], sb[i], ss[i]);
      end
      for (int c = 0; c < 13; c++) begin
         if (c < 8) begin
            i16.a = sa[c]; i16.b = sb[c]; i16.sub = ss[c]; i16.in_valid = 1'b1;
         end else begin
            i16.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (c >= 3 && c <= 10) begin
            e = se[c-3];
            chk("stream valid", i16.out_valid, 1);
            chk("stream sum", i16.sum, e[15:0]);
            chk("stream flags", {i16.carry, i16.overflow}, {e[16], e[17]});
         end else begin
            chk("stream gap", i16.out_valid, 0);
         end
      end

      // backpressure: fill while out_ready low, hold 3 cycles, then drain
      for (int i = 0; i < 6; i++) begin
         pa[i] = 16'h1111 * 16'(i + 1);
         pb[i] = 16'h0F0F + 16'(i * 7);
         ps[i] = 1'(i % 2);
      end
      e = model16(pa[0], pb[0], ps[0]);
      sent = 0;
      got = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (sent < 6) begin
            i16.a = pa[sent]; i16.b = pb[sent]; i16.sub = ps[sent]; i16.in_valid = 1'b1;
         end else begin
            i16.in_valid = 1'b0;
         end
         i16.out_ready = (cyc >= 7);
         #1;
         if (cyc >= 4 && cyc <= 6) begin
            chk("bp in_ready", i16.in_ready, 0);
            chk("bp held valid", i16.out_valid, 1);
            chk("bp held sum", i16.sum, e[15:0]);
            chk("bp occupancy", sent, 4);
         end
         if (i16.out_valid && i16.out_ready) begin
            chk("bp result pending", q.size() != 0, 1);
            if (q.size() != 0) begin
               front = q.pop_front();
               chk("bp sum", i16.sum, front[15:0]);
               chk("bp flags", {i16.carry, i16.overflow}, {front[16], front[17]});
            end
            got++;
         end
         if (i16.in_valid && i16.in_ready) begin
            q.push_back(model16(pa[sent], pb[sent], ps[sent]));
            sent++;
         end
         @(posedge clk); #1;
      end
      chk("bp delivered", got, 6);
      chk("bp leftover", q.size(), 0);

      // reset with 3 beats in flight: nothing emerges
      i16.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i16.a = 16'h0100 + 16'(i); i16.b = 16'h0001; i16.sub = 1'b0; i16.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      i16.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst in_ready", i16.in_ready, 0);
      chk("midrst sum cleared", i16.sum, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("midrst no result", i16.out_valid, 0);
      end

      // legacy configurations
      op4("w4 12+15", 4'd12, 4'd15, 4'd11, 1'b1, 1'b0);
      op4("w4 6+7",   4'd6,  4'd7,  4'd13, 1'b0, 1'b1);
      op4("w4 15+1",  4'd15, 4'd1,  4'd0,  1'b1, 1'b0);
      op8("w8 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      op8("w8 10-20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end
endmodule
